// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX/MEM register, data-memory handshake with ack timeout, MEM/WB register.
module mem_stage #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] res,
  input  logic [31:0] data_2,
  input  logic [4:0]  write_register,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  input  logic        zero,
  input  logic [31:0] branch_target,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [1:0]  wb_WB,
  output logic [31:0] read_data,
  output logic [31:0] alu_res,
  output logic [4:0]  write_register_WB,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        s_valid_q, s_valid_d;
  logic [31:0] res_q, res_d, data_2_q, data_2_d, bt_q, bt_d;
  logic [4:0]  wr_q, wr_d;
  logic [2:0]  m_q, m_d;
  logic [1:0]  wb_q, wb_d;
  logic        zero_q, zero_d;
  logic        wb_valid_q, wb_valid_d;
  logic [1:0]  wb_WB_q, wb_WB_d;
  logic [31:0] read_data_q, read_data_d, alu_res_q, alu_res_d;
  logic [4:0]  wr_wb_q, wr_wb_d;
  logic        mem_fault_q, mem_fault_d;

  logic mem_op, aligned, done, retire;

  always_comb begin
    mem_op    = s_valid_q & (m_q[1] | m_q[0]);
    aligned   = (res_q[1:0] == 2'b00);
    dmem_req  = mem_op & aligned & (state_q != FAULT);
    done      = dmem_req & dmem_ack;
    // A misaligned op stalls once in IDLE, then retires from FAULT.
    mem_stall = mem_op & ~done & (state_q != FAULT);
    retire    = s_valid_q & ~mem_stall;
  end

  assign dmem_we    = m_q[0] & ~m_q[1];
  assign dmem_addr  = res_q;
  assign dmem_wdata = data_2_q;
  assign pc_src     = s_valid_q & m_q[2] & zero_q;
  assign pc_branch  = bt_q;

  assign wb_valid          = wb_valid_q;
  assign wb_WB             = wb_WB_q;
  assign read_data         = read_data_q;
  assign alu_res           = alu_res_q;
  assign write_register_WB = wr_wb_q;
  assign mem_fault         = mem_fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!aligned) begin
            state_d = FAULT;
          end else if (!dmem_ack) begin
            state_d = BUSY;
            cnt_d   = 8'd0;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
        end else if (cnt_q + 8'd1 >= TMO) begin
          state_d = FAULT;
          cnt_d   = TMO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid_d = s_valid_q;
    res_d     = res_q;
    data_2_d  = data_2_q;
    wr_d      = wr_q;
    m_d       = m_q;
    wb_d      = wb_q;
    zero_d    = zero_q;
    bt_d      = bt_q;
    if (!mem_stall) begin
      s_valid_d = ex_valid;
      res_d     = res;
      data_2_d  = data_2;
      wr_d      = write_register;
      m_d       = m_MEM;
      wb_d      = wb_MEM;
      zero_d    = zero;
      bt_d      = branch_target;
    end
  end

  always_comb begin
    wb_valid_d  = retire;
    wb_WB_d     = wb_WB_q;
    alu_res_d   = alu_res_q;
    wr_wb_d     = wr_wb_q;
    read_data_d = read_data_q;
    mem_fault_d = mem_fault_q;
    if (retire) begin
      wb_WB_d   = (state_q == FAULT) ? 2'b00 : wb_q;
      alu_res_d = res_q;
      wr_wb_d   = wr_q;
      if (done && m_q[1]) read_data_d = dmem_rdata;
      if (state_q == FAULT) mem_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      s_valid_q   <= 1'b0;
      res_q       <= 32'd0;
      data_2_q    <= 32'd0;
      wr_q        <= 5'd0;
      m_q         <= 3'd0;
      wb_q        <= 2'd0;
      zero_q      <= 1'b0;
      bt_q        <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_WB_q     <= 2'd0;
      read_data_q <= 32'd0;
      alu_res_q   <= 32'd0;
      wr_wb_q     <= 5'd0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_valid_q   <= s_valid_d;
      res_q       <= res_d;
      data_2_q    <= data_2_d;
      wr_q        <= wr_d;
      m_q         <= m_d;
      wb_q        <= wb_d;
      zero_q      <= zero_d;
      bt_q        <= bt_d;
      wb_valid_q  <= wb_valid_d;
      wb_WB_q     <= wb_WB_d;
      read_data_q <= read_data_d;
      alu_res_q   <= alu_res_d;
      wr_wb_q     <= wr_wb_d;
      mem_fault_q <= mem_fault_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a per-instruction outcome model.
module tb_mem_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] res, data_2, branch_target, dmem_rdata;
  logic [4:0]  write_register;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        zero, dmem_ack;
  logic        mem_stall, pc_src, dmem_req, dmem_we, wb_valid, mem_fault;
  logic [31:0] pc_branch, dmem_addr, dmem_wdata, read_data, alu_res;
  logic [1:0]  wb_WB;
  logic [4:0]  write_register_WB;

  mem_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .res(res), .data_2(data_2),
    .write_register(write_register), .m_MEM(m_MEM), .wb_MEM(wb_MEM), .zero(zero),
    .branch_target(branch_target), .mem_stall(mem_stall), .pc_src(pc_src),
    .pc_branch(pc_branch), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_WB(wb_WB), .read_data(read_data),
    .alu_res(alu_res), .write_register_WB(write_register_WB), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] res, d2, bt, rdat;
    logic [4:0]  rd;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic        z;
    int          lat;
  } instr_t;

  int n_tests = 0, n_fail = 0;
  int n_stall, n_req;
  instr_t cur, nxt;

  logic        check_en = 1'b0;
  logic        exp_req, exp_stall, exp_pc_src, exp_we, exp_wb_valid, exp_fault;
  logic [31:0] exp_pc_branch, exp_addr, exp_wdata, exp_alu, exp_rdata;
  logic [1:0]  exp_wb;
  logic [4:0]  exp_wr;

  logic        pend_valid = 1'b0, pend_fault, pend_rdupd;
  logic [1:0]  pend_wb;
  logic [31:0] pend_res, pend_rdat;
  logic [4:0]  pend_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      chk("pc_src", 32'(pc_src), 32'(exp_pc_src));
      chk("pc_branch", pc_branch, exp_pc_branch);
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
      chk("wb_WB", 32'(wb_WB), 32'(exp_wb));
      chk("alu_res", alu_res, exp_alu);
      chk("write_register_WB", 32'(write_register_WB), 32'(exp_wr));
      chk("read_data", read_data, exp_rdata);
      chk("mem_fault", 32'(mem_fault), 32'(exp_fault));
    end
  end

  task automatic drive_ex(input instr_t x);
    ex_valid       = x.v;
    res            = x.res;
    data_2         = x.d2;
    write_register = x.rd;
    m_MEM          = x.m;
    wb_MEM         = x.wb;
    zero           = x.z;
    branch_target  = x.bt;
  endtask

  function automatic instr_t mk(input logic v, input logic [2:0] m, input logic [1:0] wb,
                                input logic [31:0] r, input logic [31:0] d2, input logic [4:0] rd,
                                input int lat, input logic [31:0] rdat);
    instr_t x;
    x.v = v; x.m = m; x.wb = wb; x.res = r; x.d2 = d2; x.rd = rd;
    x.lat = lat; x.rdat = rdat; x.z = 1'b0; x.bt = 32'h0000_0F00;
    return x;
  endfunction

  function automatic instr_t rnd();
    instr_t x;
    x.v    = ($urandom % 10) != 0;
    x.res  = $urandom;
    if (($urandom % 4) != 0) x.res[1:0] = 2'b00;
    x.d2   = $urandom;
    x.bt   = $urandom;
    x.rdat = $urandom;
    x.rd   = 5'($urandom);
    x.m    = 3'($urandom);
    x.wb   = 2'($urandom);
    x.z    = 1'($urandom);
    x.lat  = $urandom_range(0, 6);
    return x;
  endfunction

  // Outcome per instruction: plain op 1 cycle; misaligned 2 (stall, fault retire);
  // aligned ack at cycle lat<=T completes in lat+1; otherwise T+1 stalled cycles then fault retire.
  task automatic step(input instr_t next_in);
    logic is_mem, mis, faulted;
    int   ncyc;
    nxt     = next_in;
    is_mem  = cur.v && (cur.m[1] || cur.m[0]);
    mis     = cur.res[1:0] != 2'b00;
    faulted = is_mem && (mis || cur.lat > T);
    if (!is_mem)          ncyc = 1;
    else if (mis)         ncyc = 2;
    else if (cur.lat <= T) ncyc = cur.lat + 1;
    else                  ncyc = T + 2;
    n_stall = 0;
    n_req   = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        exp_wb_valid = pend_valid;
        if (pend_valid) begin
          exp_wb  = pend_wb;
          exp_alu = pend_res;
          exp_wr  = pend_rd;
          if (pend_fault) exp_fault = 1'b1;
          if (pend_rdupd) exp_rdata = pend_rdat;
        end
      end else begin
        exp_wb_valid = 1'b0;
      end
      exp_req       = is_mem && !mis && (c <= T);
      exp_stall     = is_mem && (c < ncyc - 1);
      exp_pc_src    = cur.v && cur.m[2] && cur.z;
      exp_pc_branch = cur.bt;
      exp_addr      = cur.res;
      exp_we        = cur.m[0] && !cur.m[1];
      exp_wdata     = cur.d2;
      if (exp_req) begin
        dmem_ack   = (c == cur.lat);
        dmem_rdata = dmem_ack ? cur.rdat : $urandom;
      end else begin
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
      end
      check_en = 1'b1;
      if (c == ncyc - 1) drive_ex(nxt);
      @(negedge clk);
      n_stall += int'(mem_stall);
      n_req   += int'(dmem_req);
    end
    pend_valid = cur.v;
    pend_fault = faulted;
    pend_wb    = faulted ? 2'b00 : cur.wb;
    pend_res   = cur.res;
    pend_rd    = cur.rd;
    pend_rdupd = is_mem && !faulted && cur.m[1];
    pend_rdat  = cur.rdat;
    cur = nxt;
  endtask

  initial begin
    instr_t b, d, br;
    b = mk(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive_ex(b);
    exp_wb_valid = 0; exp_wb = 0; exp_alu = 0; exp_wr = 0; exp_rdata = 0; exp_fault = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_fault", 32'(mem_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = b;

    d = mk(1'b1, 3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    step(d); step(b);
    chk("alu_req_cycles", n_req, 0);
    chk("alu_stall_cycles", n_stall, 0);
    step(b);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_res_lit", alu_res, 32'h1234);
    chk("alu_rd_lit", 32'(write_register_WB), 32'd5);

    d = mk(1'b1, 3'b010, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hCAFEF00D);
    step(d); step(b);
    chk("load_req_cycles", n_req, 4);
    chk("load_stall_cycles", n_stall, 3);
    step(b);
    chk("load_read_data", read_data, 32'hCAFEF00D);
    chk("load_wb_valid", 32'(wb_valid), 32'd1);
    step(b);
    chk("load_wb_valid_once", 32'(wb_valid), 32'd0);

    d = mk(1'b1, 3'b001, 2'b00, 32'h200, 32'hA5A5A5A5, 5'd0, 0, 32'h0);
    step(d); step(b);
    chk("store_req_cycles", n_req, 1);
    chk("store_stall_cycles", n_stall, 0);
    step(b);
    chk("store_no_fault", 32'(mem_fault), 32'd0);

    d = mk(1'b1, 3'b010, 2'b11, 32'h102, 32'h0, 5'd3, 0, 32'h0);
    step(d); step(b);
    chk("mis_req_cycles", n_req, 0);
    chk("mis_stall_cycles", n_stall, 1);
    step(b);
    chk("mis_wb_WB", 32'(wb_WB), 32'd0);
    chk("mis_mem_fault", 32'(mem_fault), 32'd1);

    d = mk(1'b1, 3'b010, 2'b11, 32'h300, 32'h0, 5'd4, 99, 32'h0);
    step(d); step(b);
    chk("tmo_stall_cycles", n_stall, T + 1);
    chk("tmo_req_cycles", n_req, T + 1);
    step(b);
    chk("tmo_wb_WB", 32'(wb_WB), 32'd0);
    chk("tmo_mem_fault", 32'(mem_fault), 32'd1);

    for (int i = 0; i < 300; i++) step(rnd());

    d = mk(1'b1, 3'b010, 2'b11, 32'h400, 32'h0, 5'd9, 99, 32'h0);
    step(d);
    check_en = 1'b0;
    br = mk(1'b1, 3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    br.z = 1'b1;
    br.bt = 32'h0000_4000;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_req_before_rst", 32'(dmem_req), 32'd1);
    chk("busy_stall_before_rst", 32'(mem_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 32'd0);
    chk("arst_mem_stall", 32'(mem_stall), 32'd0);
    chk("arst_pc_src", 32'(pc_src), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_wb_WB", 32'(wb_WB), 32'd0);
    chk("arst_mem_fault", 32'(mem_fault), 32'd0);
    chk("arst_alu_res", alu_res, 32'd0);
    chk("arst_read_data", read_data, 32'd0);
    drive_ex(br);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("branch_pc_src", 32'(pc_src), 32'd1);
    chk("branch_pc_branch", pc_branch, 32'h0000_4000);
    chk("branch_no_req", 32'(dmem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
